// File: rtl/mul_seq32.sv
`default_nettype none
// ============================================================================
//  Module   : mul_seq32
//  Purpose  : Sequential radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
//             one multiplier bit per clock after a single load cycle.
//             Optional signed mode: define MUL_SIGNED_EN.
//  Revision : 1.0  initial release
// ============================================================================
module mul_seq32 #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic [2*WIDTH-1:0]   result,
   output logic                 busy,
   output logic                 done
);

   localparam int              CW     = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]   c_last = CW'(WIDTH - 1);
   localparam logic [CW-1:0]   c_one  = CW'(1);

   logic [WIDTH-1:0]    r_mcand;
   logic [2*WIDTH-1:0]  r_acc;
   logic [CW-1:0]       r_count;
   logic                r_busy;
   logic                r_done;
   logic [2*WIDTH-1:0]  r_result;

   logic [WIDTH:0]      w_sum;
   logic [2*WIDTH-1:0]  w_acc_next;
   logic [2*WIDTH-1:0]  w_final;
   logic [WIDTH-1:0]    w_load_a;
   logic [WIDTH-1:0]    w_load_b;

   // Upper half plus multiplicand keeps its carry, which becomes the new MSB after the shift
   always_comb begin
      w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
      w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
   end

`ifdef MUL_SIGNED_EN
   logic r_sign;

   // The most-negative value negates to itself, which is already its correct unsigned magnitude
   assign w_load_a = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
   assign w_load_b = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
   assign w_final  = r_sign ? (~w_acc_next + (2*WIDTH)'(1)) : w_acc_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sign <= 1'b0;
      end else if (start) begin
         r_sign <= A[WIDTH-1] ^ B[WIDTH-1];
      end
   end
`else
   assign w_load_a = A;
   assign w_load_b = B;
   assign w_final  = w_acc_next;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mcand  <= '0;
         r_acc    <= '0;
         r_count  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_mcand <= w_load_a;
            r_acc   <= {{WIDTH{1'b0}}, w_load_b};
            r_count <= '0;
            r_busy  <= 1'b1;
         end else if (r_busy) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + c_one;
            if (r_count == c_last) begin
               r_busy   <= 1'b0;
               r_done   <= 1'b1;
               r_result <= w_final;
            end
         end
      end
   end

   assign result = r_result;
   assign busy   = r_busy;
   assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_seq32
//  Purpose  : Scoreboard bench for mul_seq32 with directed and random jobs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_seq32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic [63:0] result;
   logic        busy;
   logic        done;

   mul_seq32 #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .A      (A),
      .B      (B),
      .result (result),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] prod;
      int          due;
   } exp_t;

   exp_t        sbq[$];
   int          cyc = 0;
   int          ncmp = 0;
   int          nfail = 0;
   logic        rst_evt = 1'b1;
   logic [63:0] prev_result = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_SIGNED_EN
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
`else
      logic [63:0] ua, ub;
      ua = {32'b0, a};
      ub = {32'b0, b};
      return ua * ub;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pop and compare on every done, and watch result stability otherwise
   always @(negedge clk) begin
      if (done) begin
         if (sbq.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("result", result, e.prod);
            chk("done_cycle", 64'(cyc), 64'(e.due));
            chk("busy_at_done", {63'b0, busy}, 64'd0);
         end
      end else if (rst && !rst_evt) begin
         chk("result_stable", result, prev_result);
      end
      prev_result = result;
      if (rst) rst_evt = 1'b0;
   end

   task automatic do_start(input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #2;
      // A job still due on or after this load edge is aborted by the new start
      for (int i = sbq.size() - 1; i >= 0; i--)
         if (sbq[i].due >= cyc + 1) sbq.delete(i);
      A = a;
      B = b;
      start = 1'b1;
      sbq.push_back('{ref_mul(a, b), cyc + 33});
      @(posedge clk);
      #2;
      start = 1'b0;
      A = $urandom;
      B = $urandom;
      chk("busy_after_load", {63'b0, busy}, 64'd1);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b0;
      rst_evt = 1'b1;
      sbq.delete();
      #1;
      chk("reset_result", result, 64'd0);
      chk("reset_busy", {63'b0, busy}, 64'd0);
      chk("reset_done", {63'b0, done}, 64'd0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
   endtask

   initial begin
      logic [31:0] ra, rb;
      int          wait_n;
      int          guard;

      #1;
      chk("por_result", result, 64'd0);
      chk("por_busy", {63'b0, busy}, 64'd0);
      chk("por_done", {63'b0, done}, 64'd0);
      wait_cycles(2);
      #2;
      rst = 1'b1;

      // Small product with full latency
      do_start(32'h0000000F, 32'h00000003);
      wait_cycles(34);
      chk("t1_result_hold", result, 64'h2D);

      // Zero multiplier still runs the full length
      do_start(32'h11111111, 32'h0);
      wait_cycles(34);

      // Largest operands
      do_start(32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_cycles(34);

      // Reset mid-operation discards the job
      do_start(32'd7, 32'd9);
      wait_cycles(8);
      do_reset();
      wait_cycles(40);
      chk("t4_idle_result", result, 64'd0);
      chk("t4_idle_busy", {63'b0, busy}, 64'd0);

      // Restart while busy: only the second job completes
      do_start(32'd5, 32'd5);
      wait_cycles(2);
      do_start(32'd6, 32'd7);
      wait_cycles(34);
      chk("t5_result", result, 64'd42);

`ifdef MUL_SIGNED_EN
      do_start(32'hFFFFFFF1, 32'd3);
      wait_cycles(34);
      do_start(32'h80000000, 32'h80000000);
      wait_cycles(34);
`endif

      // Random jobs, some overlapping so they abort
      for (int k = 0; k < 30; k++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'h0;
            1: ra = 32'h80000000;
            2: rb = 32'hFFFFFFFF;
            default: ;
         endcase
         do_start(ra, rb);
         if ($urandom_range(0, 4) == 0) wait_n = $urandom_range(0, 31);
         else                           wait_n = $urandom_range(32, 40);
         wait_cycles(wait_n);
      end

      guard = 0;
      while (sbq.size() != 0 && guard < 100) begin
         @(posedge clk);
         guard++;
      end
      @(negedge clk);
      #1;
      chk("drain_pending", 64'(sbq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
`default_nettype wire
